// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: register offsets, CTRL/STATUS bit positions and FSM encoding for dma_ctrl.
package dma_ctrl_pkg;
  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN_LO = 3'd4;
  localparam logic [2:0] REG_LEN_HI = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;
  localparam int CTRL_START   = 0;
  localparam int CTRL_SRC_FIX = 1;
  localparam int CTRL_DST_FIX = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_ABORT   = 7;
  localparam int ST_BUSY      = 7;
  localparam int ST_DONE      = 6;
  localparam int ST_ABORTED   = 5;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_WR,
    S_HAND,
    S_GAP
  } state_t;
endpackage

// File: rtl/dma_ctrl.sv
// dma_ctrl: CPU-programmed byte-copy DMA that stalls the 6502 via RDY and owns the bus in bursts.
module dma_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int BURST = 16,
  parameter int GAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq,
  output logic        cpu_rdy,
  output logic        dma_act,
  output logic [15:0] dma_ab,
  output logic        dma_we,
  output logic [7:0]  dma_do,
  input  logic [7:0]  bus_di
);
  state_t state, next;
  logic [15:0] src, dst, len, bcnt, gcnt;
  logic src_fix, dst_fix, ie, done, aborted;
  logic busy, rd, ctrl_wr, start, abort, last, burst_end;
  logic [7:0] rdata;
  logic unused;
  assign unused    = ^din[6:4];
  assign busy      = state != S_IDLE;
  assign rd        = cs & ~we;
  assign ctrl_wr   = cs & we & (rs == REG_CTRL);
  assign start     = ctrl_wr & din[CTRL_START] & ~busy;
  assign abort     = ctrl_wr & din[CTRL_ABORT] & (state == S_GAP);
  assign last      = len == 16'd1;
  assign burst_end = (BURST != 0) && (bcnt == 16'(BURST - 1));
  assign cpu_rdy   = (state == S_IDLE) || (state == S_GAP);
  assign dma_act   = (state == S_RD) || (state == S_LAT) || (state == S_WR);
  assign dma_we    = state == S_WR;
  assign dma_ab    = (state == S_RD) ? src : (state == S_WR) ? dst : 16'h0000;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = (start && len != 16'd0) ? S_RD : S_IDLE;
      S_RD:    next = S_LAT;
      S_LAT:   next = S_WR;
      S_WR:    next = (last || burst_end) ? S_HAND : S_RD;
      S_HAND:  next = (len == 16'd0) ? S_IDLE : S_GAP;
      S_GAP:   next = abort ? S_IDLE : (gcnt == 16'(GAP - 1)) ? S_RD : S_GAP;
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    rdata = 8'h00;
    case (rs)
      REG_SRC_LO: rdata = src[7:0];
      REG_SRC_HI: rdata = src[15:8];
      REG_DST_LO: rdata = dst[7:0];
      REG_DST_HI: rdata = dst[15:8];
      REG_LEN_LO: rdata = len[7:0];
      REG_LEN_HI: rdata = len[15:8];
      REG_CTRL:   rdata = {4'b0, ie, dst_fix, src_fix, 1'b0};
      default:    rdata = {busy, done, aborted, 5'b0};
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
      src_fix <= 1'b0;
      dst_fix <= 1'b0;
      ie      <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      irq     <= 1'b0;
      dout    <= '0;
      dma_do  <= '0;
    end else begin
      state <= next;
      if (cs && we && !busy)
        case (rs)
          REG_SRC_LO: src[7:0]  <= din;
          REG_SRC_HI: src[15:8] <= din;
          REG_DST_LO: dst[7:0]  <= din;
          REG_DST_HI: dst[15:8] <= din;
          REG_LEN_LO: len[7:0]  <= din;
          REG_LEN_HI: len[15:8] <= din;
          REG_CTRL:   {ie, dst_fix, src_fix} <= din[CTRL_IE:CTRL_SRC_FIX];
          default: ;
        endcase
      if (state == S_LAT) dma_do <= bus_di;
      if (state == S_WR) begin
        len  <= len - 16'd1;
        src  <= src_fix ? src : src + 16'd1;
        dst  <= dst_fix ? dst : dst + 16'd1;
        bcnt <= bcnt + 16'd1;
      end
      if (start || state == S_GAP) bcnt <= '0;
      gcnt <= (state == S_GAP) ? gcnt + 16'd1 : 16'd0;
      // a STATUS read only clears flags when nothing sets them on the same edge
      if (start) begin
        done    <= len == 16'd0;
        aborted <= 1'b0;
      end else if (state == S_WR && last) done <= 1'b1;
      else if (abort) aborted <= 1'b1;
      else if (rd && rs == REG_STATUS) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      irq <= ie & (done | aborted);
      if (rd) dout <= rdata;
    end
  end
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: register table plus scoreboarded copy transfers against a 64K memory model.
module tb_dma_ctrl;
  import dma_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset, cs, we;
  logic [2:0] rs;
  logic [7:0] din, dout, dma_do, bus_di;
  logic irq, cpu_rdy, dma_act, dma_we;
  logic [15:0] dma_ab;
  int checks = 0, failures = 0;
  typedef struct packed {logic [15:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic w; logic [2:0] r; logic [7:0] d; logic [7:0] e;} vec_t;
  wr_t exp_q[$];
  wr_t mon_e;
  vec_t vt[12];
  logic [7:0] mem[0:65535];
  logic [7:0] ref_mem[0:65535];
  logic [7:0] acia_cnt = 8'h00;
  int ref_acia = 0;
  logic [15:0] lab;
  logic lact, lwe;
  logic [7:0] ldo;

  always #5 clk = ~clk;

  dma_ctrl #(.BURST(16), .GAP(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din), .dout(dout),
    .irq(irq), .cpu_rdy(cpu_rdy), .dma_act(dma_act), .dma_ab(dma_ab), .dma_we(dma_we),
    .dma_do(dma_do), .bus_di(bus_di)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // bus sampled mid-cycle, memory updated at the edge
  always @(negedge clk) begin
    lab = dma_ab; lact = dma_act; lwe = dma_we; ldo = dma_do;
    if (reset && dma_act && dma_we) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=%h:%h expected=none", dma_ab, dma_do);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", dma_ab, mon_e.addr);
        chk("wr_data", {8'h00, dma_do}, {8'h00, mon_e.data});
      end
    end
  end

  always @(posedge clk) begin
    if (lact && lwe) mem[lab] <= ldo;
    bus_di <= (lab == 16'h2000) ? 8'hA0 + acia_cnt : mem[lab];
    if (lact && !lwe && lab == 16'h2000) acia_cnt <= acia_cnt + 8'h01;
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic cpu_write(input logic [2:0] r, input logic [7:0] d);
    @(posedge clk); #1 cs = 1'b1; we = 1'b1; rs = r; din = d;
    @(posedge clk); #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] r, output logic [7:0] d);
    @(posedge clk); #1 cs = 1'b1; we = 1'b0; rs = r;
    @(posedge clk); #1 cs = 1'b0;
    d = dout;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] r, input logic [7:0] e);
    logic [7:0] v;
    cpu_read(r, v);
    chk(name, {8'h00, v}, {8'h00, e});
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    cpu_write(REG_SRC_LO, s[7:0]); cpu_write(REG_SRC_HI, s[15:8]);
    cpu_write(REG_DST_LO, d[7:0]); cpu_write(REG_DST_HI, d[15:8]);
    cpu_write(REG_LEN_LO, n[7:0]); cpu_write(REG_LEN_HI, n[15:8]);
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n, input bit sfix);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      if (s == 16'h2000) begin
        v = 8'hA0 + 8'(ref_acia);
        ref_acia++;
      end else v = ref_mem[s];
      exp_q.push_back(wr_t'{d, v});
      ref_mem[d] = v;
      if (!sfix) s = s + 16'd1;
      d = d + 16'd1;
    end
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (cpu_rdy === v && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ram_chk(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++)
      chk("ram", {8'h00, mem[16'(d + i)]}, {8'h00, ref_mem[16'(d + i)]});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = pat(16'(i));
      ref_mem[i] = pat(16'(i));
    end
    reset = 1'b0; cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_cpu_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("rst_dma_act", {15'd0, dma_act}, 16'd0);
    chk("rst_dma_we", {15'd0, dma_we}, 16'd0);
    chk("rst_dma_ab", dma_ab, 16'h0000);
    chk("rst_dma_do", {8'h00, dma_do}, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_dout", {8'h00, dout}, 16'h0000);

    vt[0]  = '{1'b1, REG_SRC_LO, 8'h34, 8'h00};
    vt[1]  = '{1'b1, REG_SRC_HI, 8'h12, 8'h00};
    vt[2]  = '{1'b1, REG_DST_LO, 8'h78, 8'h00};
    vt[3]  = '{1'b1, REG_DST_HI, 8'h56, 8'h00};
    vt[4]  = '{1'b1, REG_LEN_LO, 8'hBC, 8'h00};
    vt[5]  = '{1'b1, REG_LEN_HI, 8'h0A, 8'h00};
    vt[6]  = '{1'b1, REG_CTRL,   8'h7E, 8'h00};
    vt[7]  = '{1'b0, REG_CTRL,   8'h00, 8'h0E};
    vt[8]  = '{1'b0, REG_SRC_HI, 8'h00, 8'h12};
    vt[9]  = '{1'b0, REG_LEN_LO, 8'h00, 8'hBC};
    vt[10] = '{1'b1, REG_CTRL,   8'h80, 8'h00};
    vt[11] = '{1'b0, REG_STATUS, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++)
      if (vt[i].w) cpu_write(vt[i].r, vt[i].d);
      else begin
        cpu_read(vt[i].r, v);
        chk($sformatf("vec%0d", i), {8'h00, v}, {8'h00, vt[i].e});
      end
    rd_chk("dst_hi", REG_DST_HI, 8'h56);
    rd_chk("ctrl_after_abort_idle", REG_CTRL, 8'h00);

    setup(16'h0100, 16'h0200, 16'd4);
    push_copy(16'h0100, 16'h0200, 4, 1'b0);
    cpu_write(REG_CTRL, 8'h01);
    chk("t1_act", {15'd0, dma_act}, 16'd1);
    run_len(1'b0, n);
    chk("t1_stall", 16'(n), 16'd13);
    rd_chk("t1_status", REG_STATUS, 8'h40);
    rd_chk("t1_src_lo", REG_SRC_LO, 8'h04);
    rd_chk("t1_src_hi", REG_SRC_HI, 8'h01);
    rd_chk("t1_dst_lo", REG_DST_LO, 8'h04);
    rd_chk("t1_len_lo", REG_LEN_LO, 8'h00);
    chk("t1_q", 16'(exp_q.size()), 16'd0);
    ram_chk(16'h0200, 4);

    setup(16'h0100, 16'h0200, 16'd0);
    cpu_write(REG_CTRL, 8'h01);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rdy !== 1'b1 || dma_act !== 1'b0) k++;
      @(posedge clk); #1;
    end
    chk("len0_bus_untouched", 16'(k), 16'd0);
    rd_chk("len0_status", REG_STATUS, 8'h40);

    setup(16'h0400, 16'h0800, 16'd40);
    push_copy(16'h0400, 16'h0800, 40, 1'b0);
    cpu_write(REG_CTRL, 8'h01);
    run_len(1'b0, n); chk("b_ten1", 16'(n), 16'd49);
    run_len(1'b1, n); chk("b_gap1", 16'(n), 16'd4);
    run_len(1'b0, n); chk("b_ten2", 16'(n), 16'd49);
    run_len(1'b1, n); chk("b_gap2", 16'(n), 16'd4);
    run_len(1'b0, n); chk("b_ten3", 16'(n), 16'd25);
    rd_chk("b_status", REG_STATUS, 8'h40);
    chk("b_q", 16'(exp_q.size()), 16'd0);
    ram_chk(16'h0800, 40);

    setup(16'h2000, 16'h0300, 16'd3);
    push_copy(16'h2000, 16'h0300, 3, 1'b1);
    cpu_write(REG_CTRL, 8'h0B);
    cs = 1'b1; we = 1'b0; rs = REG_STATUS;
    run_len(1'b0, n);
    chk("fix_stall", 16'(n), 16'd10);
    chk("fix_status_hand", {8'h00, dout}, 16'h00C0);
    chk("fix_irq_set", {15'd0, irq}, 16'd1);
    @(posedge clk); #1;
    chk("fix_status_after", {8'h00, dout}, 16'h0000);
    chk("fix_irq_clr", {15'd0, irq}, 16'd0);
    cs = 1'b0;
    rd_chk("fix_src_hi", REG_SRC_HI, 8'h20);
    rd_chk("fix_src_lo", REG_SRC_LO, 8'h00);
    rd_chk("fix_dst_lo", REG_DST_LO, 8'h03);
    chk("fix_q", 16'(exp_q.size()), 16'd0);

    setup(16'hFFFE, 16'h0000, 16'd4);
    push_copy(16'hFFFE, 16'h0000, 4, 1'b0);
    cpu_write(REG_CTRL, 8'h01);
    run_len(1'b0, n);
    chk("wrap_stall", 16'(n), 16'd13);
    rd_chk("wrap_src_lo", REG_SRC_LO, 8'h02);
    rd_chk("wrap_src_hi", REG_SRC_HI, 8'h00);
    chk("wrap_q", 16'(exp_q.size()), 16'd0);
    ram_chk(16'h0000, 4);

    setup(16'h1000, 16'h1800, 16'd40);
    push_copy(16'h1000, 16'h1800, 16, 1'b0);
    cpu_write(REG_CTRL, 8'h01);
    run_len(1'b0, n);
    chk("ab_ten1", 16'(n), 16'd49);
    cpu_write(REG_SRC_LO, 8'hFF);
    cpu_write(REG_CTRL, 8'h80);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_rdy !== 1'b1 || dma_act !== 1'b0) k++;
      @(posedge clk); #1;
    end
    chk("ab_bus_released", 16'(k), 16'd0);
    rd_chk("ab_len_lo", REG_LEN_LO, 8'h18);
    rd_chk("ab_len_hi", REG_LEN_HI, 8'h00);
    rd_chk("ab_src_lo", REG_SRC_LO, 8'h10);
    rd_chk("ab_status", REG_STATUS, 8'h20);
    rd_chk("ab_status_clr", REG_STATUS, 8'h00);
    chk("ab_q", 16'(exp_q.size()), 16'd0);

    setup(16'h0100, 16'h0500, 16'd4);
    rd_chk("pre_rst_len", REG_LEN_LO, 8'h04);
    cpu_write(REG_CTRL, 8'h01);
    k = 0;
    while (dma_we !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_wr", {15'd0, k < 100}, 16'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_cpu_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("arst_dma_act", {15'd0, dma_act}, 16'd0);
    chk("arst_dma_we", {15'd0, dma_we}, 16'd0);
    chk("arst_dma_ab", dma_ab, 16'h0000);
    chk("arst_dma_do", {8'h00, dma_do}, 16'h0000);
    chk("arst_dout", {8'h00, dout}, 16'h0000);
    @(posedge clk); #1 reset = 1'b1;
    rd_chk("arst_status", REG_STATUS, 8'h00);
    rd_chk("arst_len", REG_LEN_LO, 8'h00);
    chk("arst_q", 16'(exp_q.size()), 16'd0);
    chk("arst_no_write", {8'h00, mem[16'h0500]}, {8'h00, pat(16'h0500)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- CPU-programmed DMA controller for the 6502 system bus; copies LEN bytes from SRC to DST anywhere in the 64K map (RAM, GPIO, ACIA, ROM).
- Takes the bus by stalling the CPU via RDY; top level muxes memory address, WE and write data to dma_* while dma_act=1.
- Sits on its own chip-select page alongside RAM/GPIO/ACIA; read data registered so it joins the existing registered data mux.

Parameters:
- BURST, 16, bytes per bus tenure; 0 = never release until done.
- GAP, 4, CPU cycles granted between bursts (>=1); 16-bit counter.

Ports:
- clk  in  1  system/CPU clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  register page select
- we  in  1  CPU write enable
- rs  in  3  register select (CPU_AB[2:0])
- din  in  8  CPU write data
- dout  out  8  registered register read data
- irq  out  1  interrupt request, active-high
- cpu_rdy  out  1  CPU RDY; 0 stalls CPU
- dma_act  out  1  1 = DMA owns memory address/WE/data
- dma_ab  out  16  DMA address
- dma_we  out  1  DMA write strobe
- dma_do  out  8  DMA write data
- bus_di  in  8  system read-data mux output (valid one cycle after address)

Behaviour:
- Reset: all regs 0, state IDLE, cpu_rdy=1, dma_act=0, dma_we=0, dma_ab=0, dma_do=0, irq=0, dout=0. Reset mid-transfer aborts immediately; no status retained.
- Register map (rs): 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI, 6 CTRL, 7 STATUS.
- CTRL write: b0 START, b1 SRC_FIX, b2 DST_FIX, b3 IE, b7 ABORT; b1-b3 stored, b0/b7 are strobes. CTRL read returns stored b1-b3, others 0.
- STATUS read: b7 BUSY, b6 DONE, b5 ABORTED. A STATUS read (cs & !we & rs==7 at clock edge) clears DONE/ABORTED next cycle.
- irq = IE & (DONE | ABORTED), registered.
- dout registered from rs on every cs read cycle; SRC/DST/LEN read live values (post-transfer addresses advanced, LEN=0).
- Writes to rs 0-5 and CTRL b1-b3 ignored while BUSY; START ignored while BUSY; ABORT ignored while IDLE.
- START with LEN=0: DONE set next cycle, bus never taken, cpu_rdy stays 1.
- FSM: IDLE, RD, LAT, WR, HAND, GAP.
- IDLE + START (LEN!=0) -> RD; cpu_rdy=0, dma_act=1, BUSY=1 registered the cycle after the write.
- RD: dma_ab=SRC, dma_we=0 -> LAT.
- LAT: bus_di valid; capture into dma_do -> WR.
- WR: dma_ab=DST, dma_we=1. At exit: LEN-1; SRC+1 unless SRC_FIX; DST+1 unless DST_FIX; 16-bit wrap FFFF->0000. Next: LEN becomes 0 -> HAND (set DONE at exit); BURST!=0 and burst count reaches BURST -> HAND then GAP; else RD.
- Throughput: 3 cycles per byte.
- HAND: dma_act=0, cpu_rdy=0 for one cycle so the CPU's held address is re-presented and its read data is valid on release. Next: GAP or IDLE, with cpu_rdy=1.
- GAP: cpu_rdy=1, dma_act=0 for GAP cycles; burst counter cleared -> RD (cpu_rdy=0, dma_act=1).
- ABORT written during GAP: -> IDLE next cycle, ABORTED=1, BUSY=0, registers hold partial progress.
- DONE from a new START clears the previous DONE/ABORTED.

Decomposition:
- Shared package: register offsets, CTRL/STATUS bit positions, FSM state encoding.
- No sub-module; a single flat module. The register file and FSM are small.

Test Plan:
- SRC=0100, DST=0200, LEN=4, CTRL=01: RAM[200..203]=RAM[100..103].
  - cpu_rdy low for exactly 13 cycles (12 + HAND); DONE=1; SRC=0104, DST=0204, LEN=0.
- LEN=0, START: DONE next cycle; cpu_rdy and dma_act never change.
- BURST=16, GAP=4, LEN=40:
  - 3 tenures of 16/16/8 bytes, each followed by HAND.
  - cpu_rdy high for exactly 4 cycles in each of 2 gaps.
  - Final RAM contents correct.
- SRC=2000 with SRC_FIX, DST=0300, LEN=3, IE=1:
  - 3 reads at 2000 (ACIA data) land at 0300-0302.
  - irq=1 after DONE; STATUS read returns C0... then 00 and irq=0.
- SRC=FFFE, DST=0000, LEN=4: source wraps to 0000 after FFFF; SRC=0002 at end.
- ABORT written during first GAP of LEN=40:
  - ABORTED=1, BUSY=0, LEN=24.
- Separately, async reset asserted mid-WR: outputs reach reset values immediately.
